sync_bank_filt: RTL and testbench

- Parametrised multi-channel successor to the single-bit scan-capable synchronizer.
- WIDTH independent asynchronous inputs pass through a STAGES-deep synchronizer chain into the rclk domain.
- An optional per-bit stability filter (debounce) follows the chain; rise/fall edge pulses are generated from the filtered output.
- All state flops form one mux-scan chain (si→so under se). Used at chip/tile boundaries for straps, interrupts and status lines.

---
 rtl/sync_bank_filt_pkg.sv | 22 ++
 rtl/sync_bank_filt_bit.sv | 92 +++++++++
 rtl/sync_bank_filt.sv | 90 +++++++++
 tb/tb_sync_bank_filt.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_bank_filt_pkg.sv
// Shared helpers for the multi-channel synchronizer bank: width arithmetic
// used to size the per-bit stability counters.
package sync_bank_filt_pkg;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Counter width for a filter depth; never narrower than one bit.
    function automatic int cnt_width(input int filt);
        int w;
        w = clog2(filt);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_bank_filt_bit.sv
// One channel of the synchronizer bank: STAGES-deep capture chain plus an
// optional stability filter, each with its own scan segment.
module sync_bank_filt_bit
    import sync_bank_filt_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter int   FILT    = 0,
    parameter logic RST_BIT = 1'b0
) (
    input  logic rclk,
    input  logic rst_l,
    input  logic se,
    input  logic si,
    input  logic async_in,
    input  logic filt_si,
    output logic so,
    output logic filt_so,
    output logic sync_out
);

    logic [STAGES-1:0] st_q;
    logic [STAGES-1:0] st_d;
    logic              raw_s;

    assign raw_s = st_q[STAGES-1];
    assign so    = raw_s;

    // Chain next state: st[0] is the only flop that ever sees async_in.
    always_comb begin
        st_d = st_q;
        if (se) begin
            st_d = {st_q[STAGES-2:0], si};
        end else begin
            st_d = {st_q[STAGES-2:0], async_in};
        end
    end

    // Chain registers.
    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            st_q <= {STAGES{RST_BIT}};
        end else begin
            st_q <= st_d;
        end
    end

    generate
        if (FILT > 0) begin : g_filt
            localparam int            CW       = cnt_width(FILT);
            localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          out_q;
            logic          out_d;

            // Any cycle where raw agrees with the accepted value restarts the count.
            always_comb begin
                cnt_d = cnt_q;
                out_d = out_q;
                if (se) begin
                    out_d = filt_si;
                end else if (raw_s == out_q) begin
                    cnt_d = {CW{1'b0}};
                end else if (cnt_q == CNT_LAST) begin
                    out_d = raw_s;
                    cnt_d = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1'b1);
                end
            end

            // Filter registers; the counter is outside the scan chain and holds under se.
            always_ff @(posedge rclk) begin
                if (!rst_l) begin
                    cnt_q <= {CW{1'b0}};
                    out_q <= RST_BIT;
                end else begin
                    cnt_q <= cnt_d;
                    out_q <= out_d;
                end
            end

            assign sync_out = out_q;
            assign filt_so  = out_q;
        end else begin : g_bypass
            assign sync_out = raw_s;
            assign filt_so  = filt_si;
        end
    endgenerate

endmodule

// File: rtl/sync_bank_filt.sv
// WIDTH-channel boundary synchronizer with optional debounce, edge pulses
// and a single mux-scan chain through every state flop.
module sync_bank_filt
    import sync_bank_filt_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               STAGES  = 2,
    parameter int               FILT    = 0,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             rclk,
    input  logic             rst_l,
    input  logic             se,
    input  logic             si,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise_pls,
    output logic [WIDTH-1:0] fall_pls,
    output logic             chg,
    output logic             so
);

    // Scan taps: all chain segments first, then all filter flops, then history.
    logic [WIDTH:0]   chain_s;
    logic [WIDTH:0]   filt_s;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    assign chain_s[0] = si;
    assign filt_s[0]  = chain_s[WIDTH];

    generate
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            sync_bank_filt_bit #(
                .STAGES  (STAGES),
                .FILT    (FILT),
                .RST_BIT (RST_VAL[b])
            ) u_bit (
                .rclk     (rclk),
                .rst_l    (rst_l),
                .se       (se),
                .si       (chain_s[b]),
                .async_in (async_in[b]),
                .filt_si  (filt_s[b]),
                .so       (chain_s[b+1]),
                .filt_so  (filt_s[b+1]),
                .sync_out (sync_out[b])
            );
        end
    endgenerate

    // History next state: shift under scan, otherwise track sync_out.
    always_comb begin
        prev_d = prev_q;
        if (se) begin
            prev_d[0] = filt_s[WIDTH];
            for (int i = 1; i < WIDTH; i++) begin
                prev_d[i] = prev_q[i-1];
            end
        end else begin
            prev_d = sync_out;
        end
    end

    // History register.
    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Edge pulses; suppressed while the chain is shifting.
    always_comb begin
        rise_pls = {WIDTH{1'b0}};
        fall_pls = {WIDTH{1'b0}};
        if (se) begin
            rise_pls = {WIDTH{1'b0}};
            fall_pls = {WIDTH{1'b0}};
        end else begin
            rise_pls = sync_out & ~prev_q;
            fall_pls = ~sync_out & prev_q;
        end
    end

    assign chg = |(rise_pls | fall_pls);
    assign so  = prev_q[WIDTH-1];

endmodule

// File: tb/tb_sync_bank_filt.sv
// Scoreboard bench for sync_bank_filt: four configurations run side by side,
// expectations are queued with a target cycle and checked by a monitor.
module tb_sync_bank_filt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic se, si;
    logic rst_a, rst_b, rst_c, rst_d;
    logic [7:0] ai_a, ai_b, ai_c;
    logic [3:0] ai_d;
    logic [7:0] sync_a, rise_a, fall_a, sync_b, rise_b, fall_b, sync_c, rise_c, fall_c;
    logic [3:0] sync_d, rise_d, fall_d;
    logic chg_a, chg_b, chg_c, chg_d, so_a, so_b, so_c, so_d;

    sync_bank_filt #(.WIDTH(8), .STAGES(2), .FILT(0), .RST_VAL(8'hA5)) u_a (
        .rclk(clk), .rst_l(rst_a), .se(se), .si(si), .async_in(ai_a),
        .sync_out(sync_a), .rise_pls(rise_a), .fall_pls(fall_a), .chg(chg_a), .so(so_a));
    sync_bank_filt #(.WIDTH(8), .STAGES(3), .FILT(0), .RST_VAL(8'h00)) u_b (
        .rclk(clk), .rst_l(rst_b), .se(se), .si(si), .async_in(ai_b),
        .sync_out(sync_b), .rise_pls(rise_b), .fall_pls(fall_b), .chg(chg_b), .so(so_b));
    sync_bank_filt #(.WIDTH(8), .STAGES(2), .FILT(3), .RST_VAL(8'h00)) u_c (
        .rclk(clk), .rst_l(rst_c), .se(se), .si(si), .async_in(ai_c),
        .sync_out(sync_c), .rise_pls(rise_c), .fall_pls(fall_c), .chg(chg_c), .so(so_c));
    sync_bank_filt #(.WIDTH(4), .STAGES(2), .FILT(2), .RST_VAL(4'h9)) u_d (
        .rclk(clk), .rst_l(rst_d), .se(se), .si(si), .async_in(ai_d),
        .sync_out(sync_d), .rise_pls(rise_d), .fall_pls(fall_d), .chg(chg_d), .so(so_d));

    localparam int DA = 0, DB = 1, DC = 2, DD = 3;
    localparam int F_SYNC = 0, F_RISE = 1, F_FALL = 2, F_CHG = 3, F_SO = 4;
    string dname [4] = '{"A", "B", "C", "D"};
    string fname [5] = '{"sync_out", "rise_pls", "fall_pls", "chg", "so"};

    typedef struct {
        int         at;
        int         dut;
        int         fld;
        logic [7:0] exp;
    } exp_t;

    exp_t sbq[$];
    exp_t keep[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic exp_push(input int dly, input int dut, input int fld, input logic [7:0] val);
        exp_t e;
        e.at  = cyc + dly;
        e.dut = dut;
        e.fld = fld;
        e.exp = val;
        sbq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] act(input int dut, input int fld);
        logic [7:0] s, r, f;
        logic c, o;
        case (dut)
            DA:      begin s = sync_a; r = rise_a; f = fall_a; c = chg_a; o = so_a; end
            DB:      begin s = sync_b; r = rise_b; f = fall_b; c = chg_b; o = so_b; end
            DC:      begin s = sync_c; r = rise_c; f = fall_c; c = chg_c; o = so_c; end
            default: begin s = {4'h0, sync_d}; r = {4'h0, rise_d}; f = {4'h0, fall_d}; c = chg_d; o = so_d; end
        endcase
        case (fld)
            F_SYNC:  return s;
            F_RISE:  return r;
            F_FALL:  return f;
            F_CHG:   return {7'd0, c};
            default: return {7'd0, o};
        endcase
    endfunction

    // Monitor: on every falling edge, check all expectations due this cycle.
    initial begin
        forever begin
            @(negedge clk);
            keep = {};
            foreach (sbq[i]) begin
                if (sbq[i].at <= cyc) begin
                    n_tests++;
                    if (act(sbq[i].dut, sbq[i].fld) !== sbq[i].exp) begin
                        n_fail++;
                        $display("FAIL %s.%s cycle %0d: got %h expected %h", dname[sbq[i].dut],
                                 fname[sbq[i].fld], cyc, act(sbq[i].dut, sbq[i].fld), sbq[i].exp);
                    end
                end else begin
                    keep.push_back(sbq[i]);
                end
            end
            sbq = keep;
        end
    end

    logic [31:0] stream;

    initial begin
        se = 1'b0; si = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        ai_a = 8'h00; ai_b = 8'h00; ai_c = 8'h00; ai_d = 4'h0;
        stream = {16'hC3A5, 16'h0003};

        // Reset held for two edges
        tick(1);
        n_tests++;
        if (sync_a !== 8'hA5) begin
            n_fail++;
            $display("FAIL A.sync_out in reset: got %h expected a5", sync_a);
        end
        exp_push(0, DA, F_SYNC, 8'hA5);
        exp_push(0, DA, F_RISE, 8'h00);
        exp_push(0, DA, F_FALL, 8'h00);
        exp_push(0, DA, F_CHG, 8'h00);
        exp_push(0, DA, F_SO, 8'h01);
        exp_push(0, DD, F_SYNC, 8'h09);
        exp_push(0, DD, F_SO, 8'h01);
        tick(1);
        exp_push(0, DA, F_SYNC, 8'hA5);
        exp_push(0, DA, F_FALL, 8'h00);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        exp_push(1, DA, F_SYNC, 8'hA5);
        exp_push(1, DA, F_FALL, 8'h00);
        exp_push(2, DA, F_SYNC, 8'h00);
        exp_push(2, DA, F_FALL, 8'hA5);
        exp_push(2, DA, F_RISE, 8'h00);
        exp_push(2, DA, F_CHG, 8'h01);
        exp_push(3, DA, F_FALL, 8'h00);
        exp_push(3, DA, F_CHG, 8'h00);
        tick(4);

        // Latency through a 3-stage chain, then simultaneous rise and fall
        ai_b = 8'h81;
        exp_push(2, DB, F_SYNC, 8'h00);
        exp_push(3, DB, F_SYNC, 8'h81);
        exp_push(3, DB, F_RISE, 8'h81);
        exp_push(3, DB, F_FALL, 8'h00);
        exp_push(3, DB, F_CHG, 8'h01);
        exp_push(4, DB, F_RISE, 8'h00);
        exp_push(4, DB, F_CHG, 8'h00);
        tick(4);
        ai_b = 8'h18;
        exp_push(2, DB, F_SYNC, 8'h81);
        exp_push(3, DB, F_SYNC, 8'h18);
        exp_push(3, DB, F_RISE, 8'h18);
        exp_push(3, DB, F_FALL, 8'h81);
        exp_push(3, DB, F_CHG, 8'h01);
        exp_push(4, DB, F_RISE, 8'h00);
        exp_push(4, DB, F_FALL, 8'h00);
        tick(5);

        // Filter: 1- and 2-cycle glitches are rejected
        ai_c = 8'h01;
        tick(1);
        ai_c = 8'h00;
        for (int k = 0; k < 7; k++) begin
            exp_push(k, DC, F_SYNC, 8'h00);
            exp_push(k, DC, F_RISE, 8'h00);
        end
        tick(7);
        ai_c = 8'h01;
        tick(2);
        ai_c = 8'h00;
        for (int k = 0; k < 7; k++) begin
            exp_push(k, DC, F_SYNC, 8'h00);
            exp_push(k, DC, F_CHG, 8'h00);
        end
        tick(7);

        // Filter: a held change appears after STAGES+FILT edges
        ai_c = 8'h01;
        exp_push(4, DC, F_SYNC, 8'h00);
        exp_push(5, DC, F_SYNC, 8'h01);
        exp_push(5, DC, F_RISE, 8'h01);
        exp_push(6, DC, F_RISE, 8'h00);
        exp_push(6, DC, F_SYNC, 8'h01);
        tick(8);
        ai_c = 8'h00;
        exp_push(4, DC, F_SYNC, 8'h01);
        exp_push(5, DC, F_SYNC, 8'h00);
        exp_push(5, DC, F_FALL, 8'h01);
        tick(8);

        // Reset with a count of 2 pending discards it
        ai_c = 8'h01;
        tick(4);
        rst_c = 1'b0;
        exp_push(1, DC, F_SYNC, 8'h00);
        exp_push(1, DC, F_RISE, 8'h00);
        exp_push(1, DC, F_CHG, 8'h00);
        tick(1);
        rst_c = 1'b1;
        exp_push(4, DC, F_SYNC, 8'h00);
        exp_push(5, DC, F_SYNC, 8'h01);
        exp_push(5, DC, F_RISE, 8'h01);
        tick(8);

        // Scan on D: park bit0 with count 1, shift 32 bits, check so stream
        ai_d = 4'h1;
        tick(3);
        se = 1'b1;
        exp_push(0, DD, F_SO, 8'h00);
        for (int k = 0; k < 16; k++) begin
            exp_push(16 + k, DD, F_SO, {7'd0, stream[31-k]});
        end
        for (int k = 0; k < 32; k++) begin
            exp_push(k, DD, F_CHG, 8'h00);
            exp_push(k, DD, F_RISE, 8'h00);
            exp_push(k, DD, F_FALL, 8'h00);
        end
        for (int k = 0; k < 32; k++) begin
            si = stream[31-k];
            tick(1);
        end
        se = 1'b0;
        si = 1'b0;
        exp_push(0, DD, F_SYNC, 8'h00);
        exp_push(0, DD, F_RISE, 8'h00);
        exp_push(1, DD, F_SYNC, 8'h01);
        exp_push(1, DD, F_RISE, 8'h01);
        exp_push(1, DD, F_CHG, 8'h01);
        exp_push(2, DD, F_RISE, 8'h00);
        tick(5);

        // Reset beats scan enable
        exp_push(0, DD, F_SO, 8'h00);
        se = 1'b1;
        rst_d = 1'b0;
        tick(1);
        n_tests++;
        if (sync_d !== 4'h9) begin
            n_fail++;
            $display("FAIL D.sync_out reset over scan: got %h expected 9", sync_d);
        end
        exp_push(0, DD, F_SO, 8'h01);
        exp_push(0, DD, F_SYNC, 8'h09);
        exp_push(0, DD, F_CHG, 8'h00);
        tick(1);
        se = 1'b0;
        rst_d = 1'b1;
        tick(2);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        foreach (sbq[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.%s due cycle %0d: never checked, expected %h", dname[sbq[i].dut],
                     fname[sbq[i].fld], sbq[i].at, sbq[i].exp);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
